// File: rtl/eep_arb_pkg.sv
// eep_arb_pkg: shared types and constants for the EEPROM access arbiter.
package eep_arb_pkg;
   typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE} state_t;
   typedef enum logic {OWN_LP = 1'b0, OWN_CM = 1'b1} owner_t;
   localparam logic [1:0] ADDR_XSET = 2'b00;
   localparam logic [1:0] ADDR_P    = 2'b01;
   localparam logic [1:0] ADDR_I    = 2'b10;
   localparam logic [1:0] ADDR_D    = 2'b11;
   localparam int unsigned CHRG_CYCLES_DEF = 32'h249F00;
endpackage

// File: rtl/eep_chrg_timer.sv
// eep_chrg_timer: charge-pump window down-counter; done_o marks the last cycle of the window.
module eep_chrg_timer import eep_arb_pkg::*; #(
   parameter int unsigned CHRG_CYCLES = CHRG_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic en_i,
   output logic done_o
);
   localparam int CW = $clog2(CHRG_CYCLES + 1);
   logic [CW-1:0] cnt_q, cnt_d;
   // clear reloads the full window; decrement stops at zero so the count never wraps
   always_comb cnt_d = clr_i ? CW'(CHRG_CYCLES) : (en_i && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else cnt_q <= cnt_d;
   end
   assign done_o = (cnt_q == CW'(1));
endmodule

// File: rtl/eep_arb.sv
// eep_arb: arbitrates the EEPROM port between control loop and command path and sequences reads/writes.
// EEP_ARB_RR_EN selects round-robin tie-breaking; otherwise the control loop wins ties.
module eep_arb import eep_arb_pkg::*; #(
   parameter int unsigned DATA_W      = 14,
   parameter int unsigned CHRG_CYCLES = CHRG_CYCLES_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              lp_req,
   input  logic [1:0]        lp_addr,
   output logic              lp_ack,
   input  logic              cm_req,
   input  logic              cm_we,
   input  logic [1:0]        cm_addr,
   input  logic [DATA_W-1:0] cm_wdata,
   output logic              cm_ack,
   output logic [DATA_W-1:0] rd_data,
   output logic              busy,
   output logic [1:0]        eep_addr,
   output logic              eep_cs_n,
   output logic              eep_r_w_n,
   output logic [DATA_W-1:0] eep_wdata,
   output logic              chrg_pmp_en,
   input  logic [DATA_W-1:0] eep_rd_data
);
   state_t state_q, state_d;
   owner_t owner_q, owner_d;
   logic [1:0] addr_q, addr_d;
   logic we_q, we_d;
   logic [DATA_W-1:0] wdata_q, wdata_d, rd_q, rd_d;
   logic lp_ack_q, lp_ack_d, cm_ack_q, cm_ack_d;
   logic lp_v, cm_v, pick_cm, grant, done, acc_end;
   // a requester is invisible during its own ack cycle so a held level is not re-granted
   assign lp_v = lp_req & ~lp_ack_q;
   assign cm_v = cm_req & ~cm_ack_q;
   assign grant = (state_q == ST_IDLE) & (lp_v | cm_v);
   assign acc_end = (state_q == ST_READ) | ((state_q == ST_WRITE) & done);
`ifdef EEP_ARB_RR_EN
   owner_t last_q;
   assign pick_cm = cm_v & (~lp_v | (last_q == OWN_LP));
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) last_q <= OWN_CM;
      else if (grant) last_q <= owner_d;
   end
`else
   assign pick_cm = cm_v & ~lp_v;
`endif
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      addr_d = addr_q;
      we_d = we_q;
      wdata_d = wdata_q;
      if (grant) begin
         owner_d = pick_cm ? OWN_CM : OWN_LP;
         addr_d = pick_cm ? cm_addr : lp_addr;
         we_d = pick_cm & cm_we;
         wdata_d = pick_cm ? cm_wdata : '0;
         state_d = (pick_cm & cm_we) ? ST_WRITE : ST_READ;
      end else if (acc_end) begin
         state_d = ST_IDLE;
      end
   end
   assign lp_ack_d = acc_end & (owner_q == OWN_LP);
   assign cm_ack_d = acc_end & (owner_q == OWN_CM);
   assign rd_d = (state_q == ST_READ) ? eep_rd_data : rd_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         owner_q <= OWN_LP;
         addr_q <= '0;
         we_q <= 1'b0;
         wdata_q <= '0;
         rd_q <= '0;
         lp_ack_q <= 1'b0;
         cm_ack_q <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         addr_q <= addr_d;
         we_q <= we_d;
         wdata_q <= wdata_d;
         rd_q <= rd_d;
         lp_ack_q <= lp_ack_d;
         cm_ack_q <= cm_ack_d;
      end
   end
   eep_chrg_timer #(.CHRG_CYCLES(CHRG_CYCLES)) u_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr_i  (grant & pick_cm & cm_we),
      .en_i   (state_q == ST_WRITE),
      .done_o (done)
   );
   // EEPROM pins decode from registered state only
   assign busy = (state_q != ST_IDLE);
   assign eep_cs_n = ~busy;
   assign eep_r_w_n = ~busy | ~we_q;
   assign chrg_pmp_en = (state_q == ST_WRITE);
   assign eep_addr = busy ? addr_q : '0;
   assign eep_wdata = chrg_pmp_en ? wdata_q : '0;
   assign rd_data = rd_q;
   assign lp_ack = lp_ack_q;
   assign cm_ack = cm_ack_q;
endmodule

// File: tb/tb_eep_arb.sv
// tb_eep_arb: randomized scoreboard bench for eep_arb with an EEPROM emulator and access-order reference model.
module tb_eep_arb;
   import eep_arb_pkg::*;
   localparam int DW = 14;
   localparam int CC = 16;
`ifdef EEP_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif
   typedef struct {bit cm; bit we; logic [1:0] addr; logic [DW-1:0] data;} acc_t;
   logic clk = 0, rst_n = 0, lp_req = 0, cm_req = 0, cm_we = 0;
   logic [1:0] lp_addr = 0, cm_addr = 0, eep_addr;
   logic [DW-1:0] cm_wdata = 0, eep_rd_data, rd_data, eep_wdata;
   logic lp_ack, cm_ack, busy, eep_cs_n, eep_r_w_n, chrg_pmp_en;
   logic [DW-1:0] emu_mem [4] = '{14'h2BCD, 14'h0123, 14'h1A5A, 14'h3F00};
   logic [DW-1:0] ref_mem [4];
   acc_t acc_q[$], ack_q[$];
   acc_t cur, ea, ek;
   int checks = 0, failures = 0, cyc = 0, ack_cnt = 0, run_end = -10, run = 0;
   bit run_bad = 0, ref_last_cm = 1;
   logic [DW-1:0] last_rd = 0;

   eep_arb #(.DATA_W(DW), .CHRG_CYCLES(CC)) dut (
      .clk(clk), .rst_n(rst_n), .lp_req(lp_req), .lp_addr(lp_addr), .lp_ack(lp_ack),
      .cm_req(cm_req), .cm_we(cm_we), .cm_addr(cm_addr), .cm_wdata(cm_wdata), .cm_ack(cm_ack),
      .rd_data(rd_data), .busy(busy), .eep_addr(eep_addr), .eep_cs_n(eep_cs_n),
      .eep_r_w_n(eep_r_w_n), .eep_wdata(eep_wdata), .chrg_pmp_en(chrg_pmp_en),
      .eep_rd_data(eep_rd_data)
   );

   always #5 clk = ~clk;
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!eep_cs_n && !eep_r_w_n) emu_mem[eep_addr] <= eep_wdata;
   end
   assign eep_rd_data = (!eep_cs_n && eep_r_w_n) ? emu_mem[eep_addr] : '0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic bad(input string nm);
      checks++;
      failures++;
      $display("FAIL %s (cycle %0d)", nm, cyc);
   endtask

   // reference model: memory contents and access order in terms of whole transactions
   task automatic expect_acc(input bit cm, input bit we, input logic [1:0] a, input logic [DW-1:0] d);
      acc_t e;
      e.cm = cm;
      e.we = we;
      e.addr = a;
      if (we) ref_mem[a] = d;
      e.data = we ? d : ref_mem[a];
      ref_last_cm = cm;
      acc_q.push_back(e);
      ack_q.push_back(e);
   endtask

   // monitor: EEPROM pin activity and acknowledges, checked against the queued expectations
   always @(negedge clk) begin
      if (!rst_n) run = 0;
      else if (!eep_cs_n) begin
         if (run == 0) begin
            cur.we = !eep_r_w_n;
            cur.addr = eep_addr;
            cur.data = eep_wdata;
            run_bad = 0;
         end else if (eep_addr !== cur.addr || eep_wdata !== cur.data || eep_r_w_n !== !cur.we) run_bad = 1;
         if (chrg_pmp_en !== cur.we || busy !== 1'b1) run_bad = 1;
         run++;
      end else begin
         chk("idle_outs", {busy, eep_r_w_n, chrg_pmp_en, eep_addr, eep_wdata}, {1'b0, 1'b1, 1'b0, 2'b00, 14'h0});
         if (run > 0) begin
            if (acc_q.size() == 0) bad("acc_unexpected");
            else begin
               ea = acc_q.pop_front();
               chk("acc_we", cur.we, ea.we);
               chk("acc_addr", cur.addr, ea.addr);
               chk("acc_len", run, ea.we ? CC : 1);
               chk("acc_wdata", cur.data, ea.we ? ea.data : '0);
               chk("acc_stable", run_bad, 0);
            end
            run_end = cyc;
            run = 0;
         end
      end
      if (rst_n && (lp_ack || cm_ack)) begin
         ack_cnt++;
         chk("ack_excl", lp_ack & cm_ack, 0);
         chk("ack_lat", cyc, run_end);
         if (ack_q.size() == 0) bad("ack_unexpected");
         else begin
            ek = ack_q.pop_front();
            chk("ack_who", cm_ack, ek.cm);
            if (!ek.we) last_rd = ek.data;
            if (ek.we) chk("rd_hold", rd_data, last_rd);
            else chk("rd_data", rd_data, last_rd);
         end
      end
   end

   // modes: 0 lp read, 1 cm access, 2 simultaneous, 3 lp raised in write cycle 3, 4 cm dropped mid-write
   task automatic txn(input int mode, input logic [1:0] la, input logic [1:0] ca, input bit cw_in, input logic [DW-1:0] cd);
      bit cw, lp_pend, cm_pend, late, nxt;
      int wc;
      cw = (mode >= 3) ? 1'b1 : cw_in;
      if (mode == 0) expect_acc(0, 0, la, '0);
      else if (mode == 1 || mode == 4) expect_acc(1, cw, ca, cd);
      else if (mode == 2 && (!RR || ref_last_cm)) begin
         expect_acc(0, 0, la, '0);
         expect_acc(1, cw, ca, cd);
      end else begin
         expect_acc(1, cw, ca, cd);
         expect_acc(0, 0, la, '0);
      end
      lp_addr = la;
      cm_addr = ca;
      cm_we = cw;
      cm_wdata = cd;
      lp_req = (mode == 0 || mode == 2);
      cm_req = (mode != 0);
      lp_pend = lp_req;
      cm_pend = cm_req;
      late = (mode >= 3);
      nxt = 0;
      wc = 0;
      for (int c = 0; c < 4 * CC + 20 && (lp_pend || cm_pend || late); c++) begin
         @(posedge clk);
         #1;
         if (nxt) begin
            chk("lp_after_write", {eep_cs_n, eep_r_w_n, eep_addr}, {1'b0, 1'b1, la});
            nxt = 0;
         end
         if (late && chrg_pmp_en) begin
            wc++;
            if (mode == 3 && wc == 3) begin
               lp_req = 1;
               lp_pend = 1;
               late = 0;
            end
            if (mode == 4 && wc == 5) begin
               cm_req = 0;
               late = 0;
            end
         end
         if (lp_ack) begin
            lp_req = 0;
            lp_pend = 0;
         end
         if (cm_ack) begin
            cm_req = 0;
            cm_pend = 0;
            nxt = (mode == 3);
         end
      end
      chk("txn_timeout", {lp_pend, cm_pend, late}, 0);
      lp_req = 0;
      cm_req = 0;
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
   endtask

   initial begin
      int wc, ack0;
      ref_mem = emu_mem;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_outs", {lp_ack, cm_ack, busy, eep_cs_n, eep_r_w_n, chrg_pmp_en, eep_addr, eep_wdata, rd_data},
          {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 14'h0, 14'h0});
      rst_n = 1;
      @(posedge clk);
      #1;
      txn(0, ADDR_P, 0, 0, 0);
      chk("tp_read", rd_data, 14'h0123);
      txn(1, 0, ADDR_I, 1, 14'h1A5A);
      chk("tp_write_rd_hold", rd_data, 14'h0123);
      txn(3, ADDR_D, ADDR_I, 1, 14'h0F0F);
      txn(4, 0, ADDR_XSET, 1, 14'h2222);
      repeat (4) txn(2, 2'($urandom), 2'($urandom), 1'b0, 0);
      repeat (60) txn($urandom_range(0, 4), 2'($urandom), 2'($urandom), 1'($urandom), DW'($urandom));
      // asynchronous reset in write cycle 8; rewrite the stored value so the aborted write leaves memory intact
      cm_addr = ADDR_D;
      cm_we = 1;
      cm_wdata = ref_mem[3];
      cm_req = 1;
      wc = 0;
      for (int c = 0; c < 40 && wc < 8; c++) begin
         @(posedge clk);
         #1;
         if (chrg_pmp_en) wc++;
      end
      chk("rst_reached_w8", wc, 8);
      #1;
      rst_n = 0;
      cm_req = 0;
      #1;
      chk("rst_async", {chrg_pmp_en, eep_cs_n, busy, rd_data}, {1'b0, 1'b1, 1'b0, 14'h0});
      ref_last_cm = 1;
      last_rd = 0;
      ack0 = ack_cnt;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1;
      repeat (4) @(posedge clk);
      #1;
      chk("no_ack_after_rst", ack_cnt, ack0);
      chk("idle_after_rst", {busy, eep_cs_n}, {1'b0, 1'b1});
      txn(0, ADDR_D, 0, 0, 0);
      txn(2, ADDR_I, ADDR_P, 0, 0);
      repeat (3) @(posedge clk);
      #1;
      chk("queues_empty", acc_q.size() + ack_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog (cycle %0d)", cyc);
      $fatal(1, "watchdog expired");
   end
endmodule
